// File: rtl/find_max_timing_seq_pkg.sv
// ---------------------------------------------------------------------------
// find_max_pkg
//   Shared types and default widths for the sequential max-timing selector
//   and the blocks that plug into it.
//   Contents:
//     state_t       - selector FSM states (IDLE / SCAN / DONE)
//     DEF_*         - default channel count and word widths
// ---------------------------------------------------------------------------
package find_max_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N_CH     = 5;   // x, y, z, e0, e1
    localparam int DEF_N_PARAMS = 5;
    localparam int DEF_N_PHASES = 4;
    localparam int DEF_PW       = 32;
    localparam int DEF_TW       = 64;

endpackage

// File: rtl/find_max_timing_seq_if.sv
// ---------------------------------------------------------------------------
// find_max_timing_seq_if
//   Request/result bundle between the per-axis timing calculators (master
//   side) and the max-timing selector (slave side).
//   Signals:
//     start            level request, held high until finish is consumed
//     ch_mask          1 = channel takes part in the selection
//     params_flat      channel c, word p at [(c*N_PARAMS+p)*PW +: PW]
//     timing_flat      channel c, word k at [(c*N_PHASES+k)*TW +: TW]
//     max_params_flat  winner's parameter words
//     max_timing_flat  winner's timing words
//     max_idx          winner channel index
//     none_valid       ch_mask was all zero
//     busy             selector is scanning
//     finish           result valid
// ---------------------------------------------------------------------------
interface find_max_timing_seq_if
    import find_max_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int N_PARAMS = DEF_N_PARAMS,
    parameter int N_PHASES = DEF_N_PHASES,
    parameter int PW       = DEF_PW,
    parameter int TW       = DEF_TW
);
    localparam int IW = $clog2(N_CH);

    logic                         start;
    logic [N_CH-1:0]              ch_mask;
    logic [N_CH*N_PARAMS*PW-1:0]  params_flat;
    logic [N_CH*N_PHASES*TW-1:0]  timing_flat;
    logic [N_PARAMS*PW-1:0]       max_params_flat;
    logic [N_PHASES*TW-1:0]       max_timing_flat;
    logic [IW-1:0]                max_idx;
    logic                         none_valid;
    logic                         busy;
    logic                         finish;

    modport master (
        output start, ch_mask, params_flat, timing_flat,
        input  max_params_flat, max_timing_flat, max_idx, none_valid, busy, finish
    );

    modport slave (
        input  start, ch_mask, params_flat, timing_flat,
        output max_params_flat, max_timing_flat, max_idx, none_valid, busy, finish
    );

endinterface

// File: rtl/find_max_timing_seq_cmp.sv
// ---------------------------------------------------------------------------
// max_key_cmp
//   Combinational "does this candidate replace the current best" decision.
//   Unsigned compare; strict '>' so an equal key never displaces the
//   earlier (lower-index) winner.
//   Ports:
//     i_en          candidate's enable (mask) bit
//     i_key         candidate key
//     i_best_key    current best key
//     i_best_found  a best has already been recorded
//     o_take_new    candidate becomes the new best
// ---------------------------------------------------------------------------
module max_key_cmp #(
    parameter int TW = 64
) (
    input  logic          i_en,
    input  logic [TW-1:0] i_key,
    input  logic [TW-1:0] i_best_key,
    input  logic          i_best_found,
    output logic          o_take_new
);

    assign o_take_new = i_en & (~i_best_found | (i_key > i_best_key));

endmodule

// File: rtl/find_max_timing_seq.sv
// ---------------------------------------------------------------------------
// find_max_timing_seq
//   Scans N_CH motion channels one per cycle and latches the timing vector,
//   parameter vector and index of the enabled channel with the largest key
//   timing word. Ties keep the lower index; an all-zero mask reports
//   none_valid with zeroed results.
//   Ports:
//     clk      system clock
//     reset_n  synchronous reset, active-low
//     bus      find_max_timing_seq_if.slave (request inputs, result outputs)
// ---------------------------------------------------------------------------
module find_max_timing_seq
    import find_max_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int N_PARAMS  = DEF_N_PARAMS,
    parameter int N_PHASES  = DEF_N_PHASES,
    parameter int PW        = DEF_PW,
    parameter int TW        = DEF_TW,
    parameter int KEY_PHASE = N_PHASES - 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    find_max_timing_seq_if.slave  bus
);

    localparam int IW = $clog2(N_CH);
    localparam int PV = N_PARAMS * PW;
    localparam int TV = N_PHASES * TW;
    localparam logic [IW-1:0] PTR_LAST = IW'(N_CH - 1);

    // Per-channel views of the flat input buses
    logic [TW-1:0] w_key [N_CH];
    logic [PV-1:0] w_par [N_CH];
    logic [TV-1:0] w_tim [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_key[g] = bus.timing_flat[(g*N_PHASES + KEY_PHASE)*TW +: TW];
        assign w_par[g] = bus.params_flat[g*PV +: PV];
        assign w_tim[g] = bus.timing_flat[g*TV +: TV];
    end

    state_t        r_state;
    state_t        w_state_nxt;

    logic [IW-1:0] r_ptr;
    logic [TW-1:0] r_best_key;
    logic [IW-1:0] r_best_idx;
    logic          r_best_found;

    // Candidate stage: channel ptr is registered one cycle before it is
    // compared, keeping the wide channel mux out of the compare path. This
    // is what puts finish at E0+N_CH+1.
    logic [TW-1:0] r_cand_key;
    logic          r_cand_en;
    logic [IW-1:0] r_cand_idx;
    logic          r_cand_vld;
    logic          r_cand_last;

    logic [PV-1:0] r_max_params;
    logic [TV-1:0] r_max_timing;
    logic [IW-1:0] r_max_idx;
    logic          r_none_valid;
    logic          r_finish;

    logic          w_take_new;
    logic          w_upd_found;
    logic [IW-1:0] w_upd_idx;
    logic [TW-1:0] w_upd_key;
    logic          w_last_eval;

    max_key_cmp #(
        .TW (TW)
    ) u_cmp (
        .i_en         (r_cand_en),
        .i_key        (r_cand_key),
        .i_best_key   (r_best_key),
        .i_best_found (r_best_found),
        .o_take_new   (w_take_new)
    );

    // Best-so-far including the candidate being compared this cycle
    assign w_upd_found = r_best_found | w_take_new;
    assign w_upd_idx   = w_take_new ? r_cand_idx : r_best_idx;
    assign w_upd_key   = w_take_new ? r_cand_key : r_best_key;
    assign w_last_eval = r_cand_vld & r_cand_last;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (!bus.start)       w_state_nxt = ST_IDLE;
                else if (w_last_eval) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (!bus.start) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr        <= '0;
            r_best_key   <= '0;
            r_best_idx   <= '0;
            r_best_found <= 1'b0;
            r_cand_key   <= '0;
            r_cand_en    <= 1'b0;
            r_cand_idx   <= '0;
            r_cand_vld   <= 1'b0;
            r_cand_last  <= 1'b0;
            r_max_params <= '0;
            r_max_timing <= '0;
            r_max_idx    <= '0;
            r_none_valid <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ptr        <= '0;
                    r_best_key   <= '0;
                    r_best_idx   <= '0;
                    r_best_found <= 1'b0;
                    r_cand_vld   <= 1'b0;
                    r_cand_last  <= 1'b0;
                    r_max_params <= '0;
                    r_max_timing <= '0;
                    r_max_idx    <= '0;
                    r_none_valid <= 1'b0;
                    r_finish     <= 1'b0;
                end
                ST_SCAN: begin
                    // start low aborts: nothing is loaded, IDLE clears next
                    if (bus.start) begin
                        r_cand_key  <= w_key[r_ptr];
                        r_cand_en   <= bus.ch_mask[r_ptr];
                        r_cand_idx  <= r_ptr;
                        r_cand_last <= (r_ptr == PTR_LAST);
                        r_cand_vld  <= 1'b1;
                        if (r_ptr != PTR_LAST) r_ptr <= r_ptr + 1'b1;

                        if (r_cand_vld) begin
                            r_best_key   <= w_upd_key;
                            r_best_idx   <= w_upd_idx;
                            r_best_found <= w_upd_found;
                        end

                        if (w_last_eval) begin
                            r_max_params <= w_upd_found ? w_par[w_upd_idx] : '0;
                            r_max_timing <= w_upd_found ? w_tim[w_upd_idx] : '0;
                            r_max_idx    <= w_upd_found ? w_upd_idx : '0;
                            r_none_valid <= ~w_upd_found;
                            r_finish     <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!bus.start) begin
                        r_max_params <= '0;
                        r_max_timing <= '0;
                        r_max_idx    <= '0;
                        r_none_valid <= 1'b0;
                        r_finish     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.max_params_flat = r_max_params;
    assign bus.max_timing_flat = r_max_timing;
    assign bus.max_idx         = r_max_idx;
    assign bus.none_valid      = r_none_valid;
    assign bus.finish          = r_finish;
    assign bus.busy            = (r_state == ST_SCAN);

endmodule

// File: tb/tb_find_max_timing_seq.sv
// ---------------------------------------------------------------------------
// tb_find_max_timing_seq
//   Directed bench for find_max_timing_seq: default 5-channel instance plus a
//   3-channel / 16-bit-key instance for the unsigned-compare sweep.
// ---------------------------------------------------------------------------
module tb_find_max_timing_seq;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    find_max_timing_seq_if #(.N_CH(5), .N_PARAMS(5), .N_PHASES(4), .PW(32), .TW(64)) bus ();
    find_max_timing_seq_if #(.N_CH(3), .N_PARAMS(2), .N_PHASES(2), .PW(32), .TW(16)) sbus ();

    find_max_timing_seq #(
        .N_CH(5), .N_PARAMS(5), .N_PHASES(4), .PW(32), .TW(64), .KEY_PHASE(3)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    find_max_timing_seq #(
        .N_CH(3), .N_PARAMS(2), .N_PHASES(2), .PW(32), .TW(16), .KEY_PHASE(0)
    ) u_dut_small (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sbus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] keys [5];
    logic [4:0]  mask;

    // Channel c timing vector: key in word 3, recognisable filler elsewhere
    function automatic logic [255:0] tim_vec(int c);
        logic [255:0] v;
        v = '0;
        for (int k = 3; k >= 0; k--) begin
            v = v << 64;
            v[63:0] = (k == 3) ? keys[c] : 64'(64'h1000 + c*16 + k);
        end
        return v;
    endfunction

    function automatic logic [159:0] par_vec(int c);
        logic [159:0] v;
        v = '0;
        for (int p = 4; p >= 0; p--) begin
            v = v << 32;
            v[31:0] = 32'hA000_0000 + 32'(c*256 + p);
        end
        return v;
    endfunction

    task automatic apply_data();
        logic [1279:0] tf;
        logic [799:0]  pf;
        tf = '0;
        pf = '0;
        for (int c = 4; c >= 0; c--) begin
            tf = tf << 256;
            tf[255:0] = tim_vec(c);
            pf = pf << 160;
            pf[159:0] = par_vec(c);
        end
        @(negedge clk);
        bus.ch_mask     = mask;
        bus.timing_flat = tf;
        bus.params_flat = pf;
    endtask

    // Raise start before edge E0; lat = edges from E0 (E0 counts as 1..)
    // until finish is seen, i.e. finish at E0+N gives lat = N+1 - 1 = N.
    task automatic run_scan(output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);  // E0
        #1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.finish === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.start = 1'b0;
        sbus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.finish !== 1'b0) begin n_bad++; $display("FAIL reset_finish: got %b want 0", bus.finish); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.max_idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", bus.max_idx); end
        n_cmp++; if (bus.none_valid !== 1'b0) begin n_bad++; $display("FAIL reset_none: got %b want 0", bus.none_valid); end
        n_cmp++; if (bus.max_timing_flat !== 256'd0) begin n_bad++; $display("FAIL reset_timing: got %h want 0", bus.max_timing_flat); end
        n_cmp++; if (bus.max_params_flat !== 160'd0) begin n_bad++; $display("FAIL reset_params: got %h want 0", bus.max_params_flat); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        keys[0] = 64'd100; keys[1] = 64'd250; keys[2] = 64'd40; keys[3] = 64'd90; keys[4] = 64'd10;
        mask = 5'b11111;
        apply_data();
        run_scan(lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL basic_latency: got %0d want 6", lat); end
        n_cmp++; if (bus.max_idx !== 3'd1) begin n_bad++; $display("FAIL basic_idx: got %0d want 1", bus.max_idx); end
        n_cmp++; if (bus.max_timing_flat !== tim_vec(1)) begin n_bad++; $display("FAIL basic_timing: got %h want %h", bus.max_timing_flat, tim_vec(1)); end
        n_cmp++; if (bus.max_params_flat !== par_vec(1)) begin n_bad++; $display("FAIL basic_params: got %h want %h", bus.max_params_flat, par_vec(1)); end
        n_cmp++; if (bus.none_valid !== 1'b0) begin n_bad++; $display("FAIL basic_none: got %b want 0", bus.none_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done: got %b want 0", bus.busy); end
        drop_start();
    endtask

    task automatic test_tie();
        int lat;
        keys[0] = 64'd300; keys[1] = 64'd300; keys[2] = 64'd0; keys[3] = 64'd0; keys[4] = 64'd0;
        mask = 5'b11111;
        apply_data();
        run_scan(lat);
        n_cmp++; if (bus.max_idx !== 3'd0) begin n_bad++; $display("FAIL tie2_idx: got %0d want 0", bus.max_idx); end
        drop_start();
        for (int c = 0; c < 5; c++) keys[c] = 64'd7;
        apply_data();
        run_scan(lat);
        n_cmp++; if (bus.max_idx !== 3'd0) begin n_bad++; $display("FAIL tieall_idx: got %0d want 0", bus.max_idx); end
        n_cmp++; if (bus.max_timing_flat !== tim_vec(0)) begin n_bad++; $display("FAIL tieall_timing: got %h want %h", bus.max_timing_flat, tim_vec(0)); end
        drop_start();
    endtask

    task automatic test_mask();
        int lat;
        keys[0] = 64'd900; keys[1] = 64'd100; keys[2] = 64'd100; keys[3] = 64'd100; keys[4] = 64'd500;
        mask = 5'b10110;
        apply_data();
        run_scan(lat);
        n_cmp++; if (bus.max_idx !== 3'd4) begin n_bad++; $display("FAIL mask_idx: got %0d want 4", bus.max_idx); end
        n_cmp++; if (bus.max_params_flat !== par_vec(4)) begin n_bad++; $display("FAIL mask_params: got %h want %h", bus.max_params_flat, par_vec(4)); end
        drop_start();
        mask = 5'b00000;
        apply_data();
        run_scan(lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL none_latency: got %0d want 6", lat); end
        n_cmp++; if (bus.none_valid !== 1'b1) begin n_bad++; $display("FAIL none_flag: got %b want 1", bus.none_valid); end
        n_cmp++; if (bus.max_idx !== 3'd0) begin n_bad++; $display("FAIL none_idx: got %0d want 0", bus.max_idx); end
        n_cmp++; if (bus.max_timing_flat !== 256'd0) begin n_bad++; $display("FAIL none_timing: got %h want 0", bus.max_timing_flat); end
        n_cmp++; if (bus.max_params_flat !== 160'd0) begin n_bad++; $display("FAIL none_params: got %h want 0", bus.max_params_flat); end
        drop_start();
    endtask

    task automatic test_handshake();
        int lat;
        keys[0] = 64'd100; keys[1] = 64'd250; keys[2] = 64'd40; keys[3] = 64'd90; keys[4] = 64'd10;
        mask = 5'b11111;
        apply_data();
        run_scan(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.finish !== 1'b1 || bus.max_idx !== 3'd1 || bus.max_timing_flat !== tim_vec(1)) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got finish=%b idx=%0d want finish=1 idx=1", i, bus.finish, bus.max_idx);
            end
        end
        drop_start();
        n_cmp++; if (bus.finish !== 1'b0) begin n_bad++; $display("FAIL drop_finish: got %b want 0", bus.finish); end
        n_cmp++; if (bus.max_idx !== 3'd0) begin n_bad++; $display("FAIL drop_idx: got %0d want 0", bus.max_idx); end
        n_cmp++; if (bus.max_timing_flat !== 256'd0) begin n_bad++; $display("FAIL drop_timing: got %h want 0", bus.max_timing_flat); end
        n_cmp++; if (bus.max_params_flat !== 160'd0) begin n_bad++; $display("FAIL drop_params: got %h want 0", bus.max_params_flat); end
        keys[3] = 64'd900;
        apply_data();
        run_scan(lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL rescan_latency: got %0d want 6", lat); end
        n_cmp++; if (bus.max_idx !== 3'd3) begin n_bad++; $display("FAIL rescan_idx: got %0d want 3", bus.max_idx); end
        drop_start();
    endtask

    task automatic test_abort();
        int  lat;
        logic seen;
        keys[0] = 64'd100; keys[1] = 64'd250; keys[2] = 64'd40; keys[3] = 64'd90; keys[4] = 64'd10;
        mask = 5'b11111;
        apply_data();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);  // E0
        #1;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy_scan: got %b want 1", bus.busy); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);  // E0+3
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_idle: got %b want 0", bus.busy); end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.finish !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_finish: got 1 want 0"); end

        // reset mid-scan
        @(negedge clk);
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0 || bus.finish !== 1'b0) begin n_bad++; $display("FAIL rst_scan: got busy=%b finish=%b want 0/0", bus.busy, bus.finish); end
        @(negedge clk);
        bus.start = 1'b0;
        reset_n = 1'b1;

        // reset in DONE
        run_scan(lat);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.finish !== 1'b0 || bus.max_idx !== 3'd0 || bus.max_timing_flat !== 256'd0) begin
            n_bad++; $display("FAIL rst_done: got finish=%b idx=%0d want 0/0", bus.finish, bus.max_idx);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset_n = 1'b1;

        run_scan(lat);
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL post_rst_latency: got %0d want 6", lat); end
        n_cmp++; if (bus.max_idx !== 3'd1) begin n_bad++; $display("FAIL post_rst_idx: got %0d want 1", bus.max_idx); end
        drop_start();
    endtask

    task automatic test_param_sweep();
        int lat;
        @(negedge clk);
        sbus.ch_mask     = 3'b111;
        sbus.timing_flat = {16'h00C2, 16'hFFFF, 16'h00C1, 16'h8000, 16'h00C0, 16'h0001};
        sbus.params_flat = {32'h2B, 32'h2A, 32'h1B, 32'h1A, 32'h0B, 32'h0A};
        sbus.start       = 1'b1;
        @(posedge clk);  // E0
        #1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (sbus.finish === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL sweep_latency: got %0d want 4", lat); end
        n_cmp++; if (sbus.max_idx !== 2'd2) begin n_bad++; $display("FAIL sweep_idx: got %0d want 2", sbus.max_idx); end
        n_cmp++; if (sbus.max_timing_flat !== 32'h00C2_FFFF) begin n_bad++; $display("FAIL sweep_timing: got %h want 00c2ffff", sbus.max_timing_flat); end
        n_cmp++; if (sbus.max_params_flat !== 64'h0000_002B_0000_002A) begin n_bad++; $display("FAIL sweep_params: got %h want 0000002b0000002a", sbus.max_params_flat); end
        @(negedge clk);
        sbus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start        = 1'b0;
        bus.ch_mask      = '0;
        bus.params_flat  = '0;
        bus.timing_flat  = '0;
        sbus.start       = 1'b0;
        sbus.ch_mask     = '0;
        sbus.params_flat = '0;
        sbus.timing_flat = '0;
        test_reset();
        test_basic();
        test_tie();
        test_mask();
        test_handshake();
        test_abort();
        test_param_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
